// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: loader state encoding, default interface widths and the
// word-index width helper used by imem_loader.
// Ports: none (package).

package riscv_pkg;

  localparam int DEF_INST_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SHIFT      = 2;
  localparam int DEF_MEM_SIZE   = 16;

  localparam int BYTES_PER_WORD = DEF_INST_WIDTH / 8;

  // One extra bit so the index can hold MEM_SIZE itself (a full-length count).
  function automatic int idx_width(input int mem_size);
    return $clog2(mem_size) + 1;
  endfunction

  localparam int IDX_W = idx_width(DEF_MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory loader with core hold
//
// Purpose: receives a length byte followed by N little-endian instruction
// words, writes them to consecutive imem words and releases the core only
// after a complete, well-formed image has been written.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a new load (ignored mid-load)
//   rx_valid   byte-stream valid
//   rx_data    byte-stream data
//   rx_ready   byte accepted when rx_valid & rx_ready
//   wr_en      imem write strobe, one cycle per word
//   wr_addr    imem byte address of the word being written
//   wr_data    packed instruction word
//   core_hold  1 = keep data_path in reset
//   done       level, last load completed
//   error      level, last load aborted on a bad length

module imem_loader
  import riscv_pkg::*;
#(
  parameter int INST_WIDTH = DEF_INST_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam int           W_IDX   = idx_width(MEM_SIZE);
  localparam int           CNT_W   = $clog2(INST_WIDTH / 8);
  localparam logic [8:0]   MAX_LEN = 9'(MEM_SIZE);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'((INST_WIDTH / 8) - 1);

  loader_state_e         state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [W_IDX-1:0]      word_idx_q, word_idx_d;
  logic [W_IDX-1:0]      len_q, len_d;
  logic [INST_WIDTH-1:0] shreg_q, shreg_d;
  logic [INST_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;

  logic                  rx_fire;
  logic                  len_bad;
  logic [W_IDX-1:0]      word_idx_inc;

  assign rx_fire      = rx_valid & rx_ready;
  assign len_bad      = (rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN);
  assign word_idx_inc = word_idx_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      shreg_q    <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      shreg_q    <= shreg_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    shreg_d    = shreg_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          word_idx_d = '0;
          byte_cnt_d = '0;
        end
      end

      LEN: begin
        if (rx_fire) begin
          if (len_bad) begin
            state_d = ERR;
          end else begin
            len_d      = W_IDX'(rx_data);
            byte_cnt_d = '0;
            state_d    = DATA;
          end
        end
      end

      DATA: begin
        if (rx_fire) begin
          // Shift in from the top: after a full word, byte 0 sits in the LSBs.
          shreg_d    = {rx_data, shreg_q[INST_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            // The output word/address only change here, so they stay stable
            // outside the WRITE cycle and a partial word never reaches them.
            wr_data_d = {rx_data, shreg_q[INST_WIDTH-1:8]};
            wr_addr_d = DATA_WIDTH'(word_idx_q) << SHIFT;
            state_d   = WRITE;
          end
        end
      end

      WRITE: begin
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == len_q) ? DONE : DATA;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    rx_ready  = (state_q == LEN) || (state_q == DATA);
    wr_en     = (state_q == WRITE);
    core_hold = (state_q != DONE);
    done      = (state_q == DONE);
    error     = (state_q == ERR);
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
  end

endmodule
